// File: rtl/ysyx_22040632_divider.sv
// Iterative radix-2 restoring divider (64-bit and W forms, signed/unsigned) with
// RISC-V M-extension corner-case results and flush abort.
module ysyx_22040632_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_valid,
    input  logic            divw,
    input  logic            div_signed,
    input  logic            flush,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned HW = 32;
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              is_w, qneg, rneg;
    logic [XLEN-1:0]   dvs, rem, dq;
    logic [XLEN-1:0]   q_hold, r_hold;

    logic              accept;
    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs;
    logic              a_neg, b_neg;
    logic [XLEN:0]     rem_sh, rem_diff;
    logic              q_bit;
    logic [XLEN-1:0]   q_cor, r_cor, q_fin, r_fin;

    assign accept = (state == IDLE) && div_valid && !flush;

    // Operand preparation: W-form extension, then magnitude (|min| is exact as unsigned)
    always_comb begin
        a_ext = dividend;
        b_ext = divisor;
        if (divw) begin
            a_ext = {{(XLEN-HW){div_signed & dividend[HW-1]}}, dividend[HW-1:0]};
            b_ext = {{(XLEN-HW){div_signed & divisor[HW-1]}},  divisor[HW-1:0]};
        end
        a_neg = div_signed & a_ext[XLEN-1];
        b_neg = div_signed & b_ext[XLEN-1];
        a_abs = a_neg ? (XLEN'(0) - a_ext) : a_ext;
        b_abs = b_neg ? (XLEN'(0) - b_ext) : b_ext;
    end

    // One restoring step: shift remainder/dividend pair, trial-subtract
    always_comb begin
        rem_sh   = {rem, dq[XLEN-1]};
        rem_diff = rem_sh - {1'b0, dvs};
        q_bit    = ~rem_diff[XLEN];
    end

    // Sign correction; a zero divisor leaves the all-ones quotient untouched
    always_comb begin
        q_cor = (qneg && (dvs != '0)) ? (XLEN'(0) - dq) : dq;
        r_cor = rneg ? (XLEN'(0) - rem) : rem;
        q_fin = q_cor;
        r_fin = r_cor;
        if (is_w) begin
            q_fin = {{(XLEN-HW){q_cor[HW-1]}}, q_cor[HW-1:0]};
            r_fin = {{(XLEN-HW){r_cor[HW-1]}}, r_cor[HW-1:0]};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div_valid) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand latch on acceptance, then one step per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            is_w <= 1'b0;
            qneg <= 1'b0;
            rneg <= 1'b0;
            dvs  <= '0;
            rem  <= '0;
            dq   <= '0;
        end else if (accept) begin
            cnt  <= divw ? CW'(HW) : CW'(XLEN);
            is_w <= divw;
            qneg <= a_neg ^ b_neg;
            rneg <= a_neg;
            dvs  <= b_abs;
            rem  <= '0;
            dq   <= divw ? (a_abs << HW) : a_abs;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
            rem <= q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            dq  <= {dq[XLEN-2:0], q_bit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_hold <= '0;
            r_hold <= '0;
        end else if (out_valid) begin
            q_hold <= q_fin;
            r_hold <= r_fin;
        end
    end

    // Results become visible in the DONE cycle unless that cycle is flushed
    assign div_ready = (state == IDLE);
    assign out_valid = (state == DONE) && !flush;
    assign quotient  = out_valid ? q_fin : q_hold;
    assign remainder = out_valid ? r_fin : r_hold;

endmodule

// File: tb/tb_ysyx_22040632_divider.sv
// Directed-vector bench for ysyx_22040632_divider: results, latency, corner cases,
// flush and asynchronous reset.
module tb_ysyx_22040632_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] dividend, divisor;
    logic        div_valid, divw, div_signed, flush;
    logic        div_ready, out_valid;
    logic [63:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    ysyx_22040632_divider #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_valid  (div_valid),
        .divw       (divw),
        .div_signed (div_signed),
        .flush      (flush),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request at a falling edge; returns after the accepting rising edge (+#1)
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s);
        @(negedge clk);
        dividend   = a;
        divisor    = b;
        divw       = w;
        div_signed = s;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        dividend   = 64'hDEAD_BEEF_0BAD_F00D;
        divisor    = 64'h5;
        divw       = ~w;
        div_signed = ~s;
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic w, input logic s,
                       input logic [63:0] eq, input logic [63:0] er, input int elat);
        int lat;
        int ready_hi;
        lat = 0;
        ready_hi = 0;
        issue(a, b, w, s);
        check({tag, ".ready_low"}, 64'(div_ready), 64'd0);
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (div_ready) ready_hi++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".ready_busy"}, 64'(ready_hi), 64'd0);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        @(posedge clk);
        #1;
        check({tag, ".pulse_end"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(div_ready), 64'd1);
        check({tag, ".q_held"}, quotient, eq);
        check({tag, ".r_held"}, remainder, er);
    endtask

    initial begin
        int pulses;
        rst_n      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_valid  = 1'b0;
        divw       = 1'b0;
        div_signed = 1'b0;
        flush      = 1'b0;
        #1;
        check("reset.ready", 64'(div_ready), 64'd1);
        check("reset.valid", 64'(out_valid), 64'd0);
        check("reset.q", quotient, 64'd0);
        check("reset.r", remainder, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run("u64_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
        run("s64_m7_2", -64'sd7, 64'd2, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run("s64_7_m2", 64'd7, -64'sd2, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
        run("s64_div0", 64'h1234, 64'd0, 1'b0, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 65);
        run("uw_div0", 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run("s64_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
            64'h8000_0000_0000_0000, 64'd0, 65);
        run("sw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
            64'hFFFF_FFFF_8000_0000, 64'd0, 33);
        run("uw_sext", 64'hFFFF_FFFF, 64'd1, 1'b1, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);

        // Flush 10 cycles into an operation
        issue(64'd1000, 64'd9, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush.ready", 64'(div_ready), 64'd1);
        pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("flush.no_pulse", 64'(pulses), 64'd0);
        check("flush.q_held", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        run("u64_20_3", 64'd20, 64'd3, 1'b0, 1'b0, 64'd6, 64'd2, 65);

        // Flush landing in the DONE cycle
        issue(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (65) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_done.valid", 64'(out_valid), 64'd0);
        check("flush_done.q", quotient, 64'd6);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done.ready", 64'(div_ready), 64'd1);
        check("flush_done.valid_after", 64'(out_valid), 64'd0);
        check("flush_done.q_after", quotient, 64'd6);
        check("flush_done.r_after", remainder, 64'd2);

        // Asynchronous reset mid-operation
        issue(64'd500, 64'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.ready", 64'(div_ready), 64'd1);
        check("rst_mid.valid", 64'(out_valid), 64'd0);
        check("rst_mid.q", quotient, 64'd0);
        check("rst_mid.r", remainder, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("sw_m20_3", 64'h0000_0000_FFFF_FFEC, 64'd3, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040632_divider.md
# ysyx_22040632_divider

Iterative radix-2 restoring divider that implements the responder side of the `ysyx_22040632_divif` `divider` modport. The CPU's ALU extension issues a request through this block and stalls on the handshake. The block supports 64-bit and 32-bit (W) forms, and signed and unsigned division, with RISC-V M-extension corner-case semantics. A `flush` aborts an in-flight operation.

## Interface
- `XLEN`, default 64: datapath width. The W form operates on bits [31:0].
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `dividend`  in  XLEN  dividend, sampled only on acceptance.
- `divisor`  in  XLEN  divisor, sampled only on acceptance.
- `div_valid`  in  1  request valid.
- `divw`  in  1  1 = 32-bit operation.
- `div_signed`  in  1  1 = signed operation.
- `flush`  in  1  abort; highest priority.
- `div_ready`  out  1  idle; a request may be accepted.
- `out_valid`  out  1  result valid, one-cycle pulse.
- `quotient`  out  XLEN  quotient result.
- `remainder`  out  XLEN  remainder result.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **Reset:** state = IDLE, `div_ready` = 1, `out_valid` = 0, `quotient` = 0, `remainder` = 0, counter = 0.
- **IDLE:**
  - `div_ready` = 1.
  - Acceptance occurs when `div_valid && !flush` is sampled at a clock edge.
  - On acceptance, latch the operation mode and the absolute-value operands.
  - Latch the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
  - Set N = 32 if `divw`, else 64, and go to BUSY.
- **Operand preparation:**
  - W form: use bits [31:0], sign-extended if `div_signed`, else zero-extended.
  - Signed form: take the absolute value of each operand as an unsigned number. |most-negative| = 2^(w-1) is exact.
- **BUSY:**
  - One restoring step per cycle on an XLEN+1-bit partial remainder.
  - Each step: shift {partial remainder, dividend} left 1 bit, trial-subtract the divisor, keep the result if it is non-negative, and shift the quotient bit in.
  - After N steps, go to DONE.
- **DONE:**
  - Apply sign correction and register the results.
  - Negate the quotient if the quotient sign is set and divisor ≠ 0.
  - Negate the remainder if the remainder sign is set.
  - W form: sign-extend the 32-bit result bit 31 to XLEN, for signed and unsigned alike.
  - `out_valid` = 1 for this cycle only, then go to IDLE.
- **Corner cases** (fall out of the algorithm plus the divisor-zero guard above):
  - Divide by zero: quotient = all ones, remainder = dividend (W form: sign-extended dividend[31:0]).
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- **Flush:** in any state, `flush` sampled high returns the block to IDLE at the next edge.
  - Any pending result is discarded, and `quotient`/`remainder` keep their previous values.
  - `out_valid` = (state == DONE) && !flush, so a flush in DONE suppresses the pulse.
- **Held values:** `quotient`/`remainder` hold their value from the last completed operation until the next DONE.
- **Operand changes:** changes on the inputs after acceptance have no effect.

## Timing
- **Acceptance:** at edge E0; `div_ready` falls right after E0.
- **Latency:** `out_valid` is high in the cycle following edge E0+N+1.
  - 64-bit: 65 cycles after acceptance.
  - W form: 33 cycles after acceptance.
- **Next request:** `div_ready` returns to 1 in the cycle after `out_valid`. The earliest next acceptance is one edge after the `out_valid` cycle.
- **No back-pressure:** there is no result back-pressure. The CPU must capture the result during the `out_valid` cycle; the data stays stable afterwards.
- **Flush vs. request:** `flush` and `div_valid` high together in IDLE means no acceptance.
- **Reset mid-operation:** asynchronous return to the reset values listed in Operation.

## Test plan
- **Unsigned 64-bit:** 100 / 7, unsigned, 64-bit → `out_valid` exactly 65 cycles after acceptance; `quotient` = 14, `remainder` = 2; `div_ready` low throughout.
- **Signed 64-bit:** −7 / 2 → `quotient` = −3 (0xFFFF_FFFF_FFFF_FFFD), `remainder` = −1. Also 7 / −2 → `quotient` = −3, `remainder` = 1.
- **Divide by zero:**
  - Signed 64-bit, 0x1234 / 0 → `quotient` = 0xFFFF_FFFF_FFFF_FFFF, `remainder` = 0x1234.
  - Unsigned W form, 0xFFFF_FFFF / 0 → `quotient` = all ones, `remainder` = 0xFFFF_FFFF_FFFF_FFFF.
- **Overflow:**
  - 64-bit signed, 0x8000_0000_0000_0000 / −1 → `quotient` = 0x8000_0000_0000_0000, `remainder` = 0.
  - Signed W form, 0x0000_0000_8000_0000 / −1 → `quotient` = 0xFFFF_FFFF_8000_0000, `remainder` = 0, latency 33.
- **Unsigned W form sign extension:** 0xFFFF_FFFF / 1 → `quotient` = 0xFFFF_FFFF_FFFF_FFFF, `remainder` = 0.
- **Flush:**
  - Flush 10 cycles after acceptance → `out_valid` never pulses; `div_ready` is 1 the next cycle; the following request 20 / 3 → 6 rem 2.
  - Flush in the DONE cycle → no pulse.
  - `rst_n` low mid-operation → all outputs return to their reset values immediately.
